// File: rtl/mnist_fp_pkg.sv
// Shared FP32 types and constants for the MNIST datapath.
// Also holds the leading-zero counter used by the adder.
package mnist_fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [31:0] FP32_ZERO        = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN        = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_SPECIAL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_e;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       hit;
    n   = 5'd24;
    hit = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!hit && v[i]) begin
        n   = 5'(23 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/flp_adder.sv
// Combinational FP32 adder, truncating, subnormals flushed to zero.
// Inf/NaN follow IEEE propagation; NaN results are canonical qNaN.
module flp_adder
  import mnist_fp_pkg::*;
(
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] sum
);

  fp32_t       a;
  fp32_t       b;
  fp32_t       x;
  fp32_t       y;
  logic [7:0]  diff;
  logic [23:0] mx;
  logic [23:0] my;
  logic [23:0] mys;
  logic [24:0] s;
  logic [23:0] d;
  logic [4:0]  lz;
  logic [22:0] nd;
  logic        a_nan;
  logic        b_nan;

  assign a = fp32_t'(num1);
  assign b = fp32_t'(num2);

  always_comb begin
    x = a;
    y = b;
    // x always carries the larger magnitude
    if ({b.exp, b.mant} > {a.exp, a.mant}) begin
      x = b;
      y = a;
    end
    diff  = x.exp - y.exp;
    mx    = {1'b1, x.mant};
    my    = {1'b1, y.mant};
    mys   = (diff > 8'd23) ? '0 : (my >> diff);
    s     = {1'b0, mx} + {1'b0, mys};
    d     = mx - mys;
    lz    = lzc24(d);
    nd    = 23'(d << lz);
    a_nan = (a.exp == FP32_EXP_SPECIAL) && (a.mant != '0);
    b_nan = (b.exp == FP32_EXP_SPECIAL) && (b.mant != '0);
    sum   = FP32_ZERO;
    if (a_nan || b_nan) begin
      sum = FP32_QNAN;
    end else if ((a.exp == FP32_EXP_SPECIAL) &&
                 (b.exp == FP32_EXP_SPECIAL) &&
                 (a.sign != b.sign)) begin
      sum = FP32_QNAN;
    end else if (a.exp == FP32_EXP_SPECIAL) begin
      sum = a;
    end else if (b.exp == FP32_EXP_SPECIAL) begin
      sum = b;
    end else if (y.exp == 8'd0) begin
      sum = (x.exp == 8'd0) ? FP32_ZERO : x;
    end else if (x.sign == y.sign) begin
      if (s[24]) begin
        if (x.exp == 8'hFE)
          sum = {x.sign, FP32_EXP_SPECIAL, 23'd0};
        else
          sum = {x.sign, x.exp + 8'd1, s[23:1]};
      end else begin
        sum = {x.sign, x.exp, s[22:0]};
      end
    end else if (d == '0) begin
      sum = FP32_ZERO;
    end else if ({3'b0, lz} >= x.exp) begin
      sum = FP32_ZERO;
    end else begin
      sum = {x.sign, x.exp - {3'b0, lz}, nd};
    end
  end

endmodule

// File: rtl/fp32_accum_stage.sv
// Streaming FP32 reduction: sums products into one accumulator,
// emits the sum on in_last or when MAX_LEN elements were taken.
module fp32_accum_stage
  import mnist_fp_pkg::*;
#(
  parameter int MAX_LEN = 784,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_special
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  acc_state_e       state;
  acc_state_e       state_n;
  logic [31:0]      acc;
  logic [31:0]      acc_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      sum;
  logic             accept;
  logic             valid_n;
  logic [31:0]      data_n;
  logic [CNT_W-1:0] count_n;
  logic             ovf_n;
  logic             special_n;

  flp_adder u_add (
    .num1 (acc),
    .num2 (in_data),
    .sum  (sum)
  );

  assign in_ready = (state != HOLD);
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = cnt + CNT_W'(1);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    valid_n = out_valid;
    data_n  = out_data;
    count_n = out_count;
    ovf_n   = out_ovf;
    // clear wins over both accept and drain
    if (clear) begin
      state_n = IDLE;
      acc_n   = FP32_ZERO;
      cnt_n   = '0;
      valid_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc_n = in_data;
            cnt_n = CNT_W'(1);
            if (in_last) begin
              state_n = HOLD;
              valid_n = 1'b1;
              data_n  = in_data;
              count_n = CNT_W'(1);
              ovf_n   = 1'b0;
            end else begin
              state_n = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_n = sum;
            cnt_n = cnt_inc;
            if (in_last || (cnt_inc == MAX_CNT)) begin
              state_n = HOLD;
              valid_n = 1'b1;
              data_n  = sum;
              count_n = cnt_inc;
              ovf_n   = ~in_last;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_n = IDLE;
            acc_n   = FP32_ZERO;
            cnt_n   = '0;
            valid_n = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
    special_n = (data_n[30:23] == FP32_EXP_SPECIAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= FP32_ZERO;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= FP32_ZERO;
      out_count   <= '0;
      out_ovf     <= 1'b0;
      out_special <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      out_valid   <= valid_n;
      out_data    <= data_n;
      out_count   <= count_n;
      out_ovf     <= ovf_n;
      out_special <= special_n;
    end
  end

endmodule

// File: tb/tb_fp32_accum_stage.sv
// Scoreboard bench for fp32_accum_stage with MAX_LEN=4.
// Directed vectors; a monitor checks every drained result.
module tb_fp32_accum_stage;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_ovf;
  logic        out_special;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  c;
    logic        ovf;
    logic        sp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  fp32_accum_stage #(.MAX_LEN(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_ovf     (out_ovf),
    .out_special (out_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] c,
                      input logic ovf, input logic sp);
    exp_t e;
    e.d = d; e.c = c; e.ovf = ovf; e.sp = sp;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !clear) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h, want no result", out_data);
        end else begin
          e = sbq.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_count", 32'(out_count), 32'(e.c));
          chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
          chk("out_special", 32'(out_special), 32'(e.sp));
        end
        chk("in_ready_hold", 32'(in_ready), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_count"}, 32'(out_count), 32'd0);
    chk({tag, "_ovf"}, 32'(out_ovf), 32'd0);
    chk({tag, "_special"}, 32'(out_special), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin : stim
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3;
    chk_reset("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic sum and latency
    push(32'h4060_0000, 3'd3, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    chk("t1_pre_valid", 32'(out_valid), 32'd0);
    send(32'h3F00_0000, 1'b1);
    chk("t1_latency", 32'(out_valid), 32'd1);
    drain();

    // 2: backpressure
    out_ready = 1'b0;
    push(32'h4060_0000, 3'd3, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h3F00_0000, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_data", out_data, 32'h4060_0000);
      chk("t2_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_ready_after", 32'(in_ready), 32'd1);
    drain();

    // 3: forced completion at MAX_LEN; 5th starts a new sum
    push(32'h4080_0000, 3'd4, 1'b1, 1'b0);
    push(32'h4080_0000, 3'd4, 1'b1, 1'b0);
    repeat (8) send(32'h3F80_0000, 1'b0);
    drain();

    // 4: cancellation and Inf
    push(32'h0000_0000, 3'd2, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b0);
    send(32'hBF80_0000, 1'b1);
    push(32'h7F80_0000, 3'd2, 1'b0, 1'b1);
    send(32'h3F80_0000, 1'b0);
    send(32'h7F80_0000, 1'b1);
    drain();

    // 5a: clear mid-sum, element under clear discarded
    send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h4100_0000;
    in_last  = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    push(32'h4000_0000, 3'd1, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b1);
    drain();

    // 5b: async reset mid-sum
    send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(32'h4000_0000, 3'd1, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b1);
    drain();

    // clear during HOLD beats out_ready
    out_ready = 1'b0;
    send(32'h4040_0000, 1'b1);
    @(negedge clk);
    chk("hold_clr_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("hold_clr_dropped", 32'(out_valid), 32'd0);
    chk("hold_clr_ready", 32'(in_ready), 32'd1);

    // 6: bubbles, then a single element
    push(32'h4080_0000, 3'd2, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(32'h4040_0000, 1'b1);
    drain();
    push(32'h4040_0000, 3'd1, 1'b0, 1'b0);
    send(32'h4040_0000, 1'b1);
    drain();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
